pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
Supervises a clock-generator PLL from the consumer side. It drives the PLL reset, watches the PLL `locked` output, and releases the downstream video-domain reset only after lock has been continuously stable. It retries lock with a timeout, reports persistent failure, and counts lock losses. The block runs on the 50 MHz reference clock, which keeps running when the PLL output clock stops.

Parameters:
- POWERUP_CYCLES, 50: width of the PLL reset pulse in refclk cycles (1 us at 50 MHz); minimum 1.
- LOCK_TIMEOUT, 50000: cycles allowed in WAIT_LOCK before a retry (1 ms); minimum 1.
- STABLE_CYCLES, 5000: consecutive synchronized-locked cycles required before release; minimum 1.
- MAX_RETRIES, 7: lock timeouts tolerated before FAULT; 1..15.
- SYNC_STAGES, 2: synchronizer depth for pll_locked; minimum 2.

Ports:
- refclk, input, 1: 50 MHz reference clock; sole clock of the block.
- rst_n, input, 1: asynchronous active-low reset.
- pll_locked, input, 1: PLL lock indicator; asynchronous to refclk.
- restart, input, 1: synchronous single-cycle request to re-run the full sequence.
- pll_rst, output, 1: active-high PLL reset.
- domain_rst_n, output, 1: active-low reset for the PLL output-clock domain; the consumer re-synchronizes it.
- ready, output, 1: high only in RUN.
- fault, output, 1: sticky high in FAULT.
- retry_cnt, output, 4: lock timeouts in the current attempt sequence.
- lock_loss_cnt, output, 8: saturating count of lock losses seen while in RUN.

Behaviour:
- Reset values (rst_n low), applied asynchronously:
  - pll_rst=1, domain_rst_n=0, ready=0, fault=0, retry_cnt=0, lock_loss_cnt=0.
  - Synchronizer flops=0, state=RESET_PLL, cycle counter=0.
- All outputs come from registers; there are no combinational input-to-output paths.
- locked_s is pll_locked after SYNC_STAGES flops. FSM decisions use locked_s only.
- Cycle counter: a single counter, width $clog2(max(POWERUP_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1), cleared on every state entry.
- RESET_PLL:
  - pll_rst=1, domain_rst_n=0, ready=0.
  - After exactly POWERUP_CYCLES cycles in the state, go to WAIT_LOCK. pll_rst is first low in the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - pll_rst=0, domain_rst_n=0.
  - If locked_s=1, go to STABLE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1, retry_cnt increments. If the new value equals MAX_RETRIES, go to FAULT; else go to RESET_PLL.
  - If locked_s rises on the timeout cycle, lock wins: go to STABLE with no increment.
- STABLE:
  - domain_rst_n=0.
  - If locked_s=0, go to WAIT_LOCK. The counter restarts and retry_cnt is unchanged.
  - After STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN.
- RUN:
  - On the entry cycle: domain_rst_n=1, ready=1, retry_cnt cleared to 0.
  - If locked_s=0: lock_loss_cnt increments, saturating at 255. Go to RESET_PLL, where domain_rst_n=0 and ready=0 on the next cycle.
- FAULT:
  - pll_rst=1 (PLL held in reset), domain_rst_n=0, ready=0, fault=1.
  - retry_cnt holds MAX_RETRIES.
  - Only restart or rst_n leaves this state.
- restart=1 in any state:
  - Go to RESET_PLL, retry_cnt=0, fault=0.
  - lock_loss_cnt is kept.
  - restart has priority over every other transition in the same cycle.
- lock_loss_cnt is cleared only by rst_n.
- rst_n asserted mid-sequence returns all outputs to their reset values immediately. Synchronous deassertion of rst_n is the integrator's responsibility.
- Glitches on pll_locked shorter than one refclk period may be missed. This is accepted; stability is enforced by STABLE_CYCLES.

Test Plan (POWERUP_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2):
- Normal bring-up:
  - Stimulus: release rst_n; raise pll_locked 10 cycles after pll_rst falls; hold it high.
  - Required: pll_rst high for exactly 4 cycles after release; ready and domain_rst_n rise 2+8 cycles after the pll_locked edge (±1 cycle); retry_cnt=0.
- Stability glitch:
  - Stimulus: during STABLE, drop pll_locked for 3 cycles, then restore.
  - Required: return to WAIT_LOCK; ready rises only after 8 fresh consecutive locked cycles; retry_cnt stays 0; pll_rst stays 0.
- Timeout and fault:
  - Stimulus: hold pll_locked=0.
  - Required: two pll_rst pulses of 4 cycles each, 20 cycles apart from pll_rst fall; retry_cnt goes 1 then 2; fault=1 and pll_rst=1 held. Then a restart pulse gives fault=0, retry_cnt=0, and a new 4-cycle pll_rst pulse.
- Lock loss in RUN:
  - Stimulus: reach RUN; drop pll_locked 300 times via repeated loss/relock cycles.
  - Required: domain_rst_n low within SYNC_STAGES+2 cycles of each drop; a PLL reset pulse follows each drop; lock_loss_cnt saturates at 255.
- Async reset mid-operation:
  - Stimulus: assert rst_n low in the middle of STABLE.
  - Required: in the same timestep pll_rst=1, domain_rst_n=0, ready=0, lock_loss_cnt=0.
- Simultaneous events:
  - Stimulus: restart coincident with the RUN entry cycle; and, separately, pll_locked rising so that locked_s=1 on the timeout cycle.
  - Required: restart wins and the block goes to RESET_PLL; lock wins over timeout with no retry increment.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Consumer-side supervisor for a clock-generator PLL. It runs entirely on the
//   reference clock, which keeps running when the PLL output clock stops. The
//   block pulses the PLL reset and waits for lock, retrying on timeout. It
//   releases the PLL output-clock domain only after lock has held for
//   STABLE_CYCLES consecutive cycles. After MAX_RETRIES timeouts it parks in a
//   sticky fault, and it counts lock losses seen while running.
//
// Ports
//   refclk        in   reference clock, sole clock of the block
//   rst_n         in   asynchronous active-low reset
//   pll_locked    in   PLL lock indicator, asynchronous to refclk
//   restart       in   single-cycle request to re-run the whole sequence
//   pll_rst       out  active-high PLL reset
//   domain_rst_n  out  active-low reset for the PLL output-clock domain
//   ready         out  high only while running
//   fault         out  high while parked after repeated lock timeouts
//   retry_cnt     out  lock timeouts in the current attempt sequence
//   lock_loss_cnt out  saturating count of lock losses seen while running
//
// All outputs are registered and derived from the next state, so each output
// changes on the same edge as the state it belongs to.

module pll_lock_supervisor #(
  parameter int unsigned POWERUP_CYCLES = 50,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 5000,
  parameter int unsigned MAX_RETRIES    = 7,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       domain_rst_n,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  // One shared cycle counter, sized for the longest interval it must time.
  localparam int unsigned MAX_AB  = (POWERUP_CYCLES > LOCK_TIMEOUT) ? POWERUP_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] PWR_LAST    = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST    = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAULT
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   domain_rst_n_q, domain_rst_n_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic [3:0]             retry_cnt_q, retry_cnt_d;
  logic [7:0]             lock_loss_cnt_q, lock_loss_cnt_d;
  logic                   locked_s;

  // pll_locked is asynchronous; only the synchronized copy steers the FSM.
  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d          = {sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d         = state_q;
    cnt_d           = cnt_q;
    retry_cnt_d     = retry_cnt_q;
    lock_loss_cnt_d = lock_loss_cnt_q;

    unique case (state_q)
      ST_RESET_PLL: begin
        if (cnt_q == PWR_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_WAIT_LOCK: begin
        // Lock is tested before the timeout, so a lock arriving on the
        // timeout cycle wins and costs no retry.
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          retry_cnt_d = retry_cnt_q + 4'd1;
          cnt_d       = '0;
          state_d     = (retry_cnt_d == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_STABLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_RUN: begin
        if (!locked_s) begin
          if (lock_loss_cnt_q != 8'hFF) begin
            lock_loss_cnt_d = lock_loss_cnt_q + 8'd1;
          end
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      end

      ST_FAULT: begin
        // Parked with the PLL held in reset; only restart or rst_n leave.
      end

      default: begin
        state_d = ST_RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // restart overrides whatever transition was chosen above.
    if (restart) begin
      state_d     = ST_RESET_PLL;
      cnt_d       = '0;
      retry_cnt_d = '0;
    end

    // A successful bring-up ends the attempt sequence.
    if (state_d == ST_RUN) begin
      retry_cnt_d = '0;
    end

    // Outputs follow the state being entered so they are registered yet
    // aligned with the state transition.
    pll_rst_d      = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    domain_rst_n_d = (state_d == ST_RUN);
    ready_d        = (state_d == ST_RUN);
    fault_d        = (state_d == ST_FAULT);
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_RESET_PLL;
      cnt_q           <= '0;
      sync_q          <= '0;
      pll_rst_q       <= 1'b1;
      domain_rst_n_q  <= 1'b0;
      ready_q         <= 1'b0;
      fault_q         <= 1'b0;
      retry_cnt_q     <= '0;
      lock_loss_cnt_q <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      sync_q          <= sync_d;
      pll_rst_q       <= pll_rst_d;
      domain_rst_n_q  <= domain_rst_n_d;
      ready_q         <= ready_d;
      fault_q         <= fault_d;
      retry_cnt_q     <= retry_cnt_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign domain_rst_n  = domain_rst_n_q;
  assign ready         = ready_q;
  assign fault         = fault_q;
  assign retry_cnt     = retry_cnt_q;
  assign lock_loss_cnt = lock_loss_cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
//   Directed bench for pll_lock_supervisor with POWERUP_CYCLES=4,
//   LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
//   The stimulus process queues every expected output change as
//   (cycle, value, name). The monitor samples the outputs on each falling
//   edge, and whenever they change it pops the next entry and compares both
//   the value and the cycle.
//   Output vector: {pll_rst, domain_rst_n, ready, fault, retry_cnt, lock_loss_cnt}.
//   Latency of pll_locked driven on a falling edge j: the FSM acts on it at
//   rising edge j+3 (two synchronizer flops, then the state register).

module tb_pll_lock_supervisor;

  logic       refclk;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       domain_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  logic [15:0] outs;
  assign outs = {pll_rst, domain_rst_n, ready, fault, retry_cnt, lock_loss_cnt};

  pll_lock_supervisor #(
    .POWERUP_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .MAX_RETRIES    (2),
    .SYNC_STAGES    (2)
  ) dut (
    .refclk        (refclk),
    .rst_n         (rst_n),
    .pll_locked    (pll_locked),
    .restart       (restart),
    .pll_rst       (pll_rst),
    .domain_rst_n  (domain_rst_n),
    .ready         (ready),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .lock_loss_cnt (lock_loss_cnt)
  );

  // Falling edge first (t=5), rising edges at 10, 20, ...
  initial refclk = 1'b1;
  always #5 refclk = ~refclk;

  int cyc = 0;
  always @(posedge refclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int          q_cyc[$];
  logic [15:0] q_val[$];
  string       q_nm[$];

  logic       e_pr, e_dr, e_rdy, e_flt;
  logic [3:0] e_rc;
  logic [7:0] e_llc;

  task automatic push_exp(input int c, input string nm);
    q_cyc.push_back(c);
    q_val.push_back({e_pr, e_dr, e_rdy, e_flt, e_rc, e_llc});
    q_nm.push_back(nm);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge refclk);
  endtask

  // Monitor: every change of the output vector is one scoreboard comparison.
  initial begin
    logic [15:0] last;
    logic [15:0] cur;
    bit          first;
    int          ec;
    logic [15:0] ev;
    string       en;
    first = 1'b1;
    last  = '0;
    forever begin
      @(negedge refclk);
      cur = outs;
      if (first || cur != last) begin
        checks++;
        if (q_cyc.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: cycle=%0d out=%h, required no change", cyc, cur);
        end else begin
          ec = q_cyc.pop_front();
          ev = q_val.pop_front();
          en = q_nm.pop_front();
          if (cur !== ev || cyc != ec) begin
            errors++;
            $display("FAIL %s: cycle=%0d out=%h, required cycle=%0d out=%h", en, cyc, cur, ec, ev);
          end
        end
        last  = cur;
        first = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: cycle=%0d, required completion before time limit", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, d, r, c1;
    rst_n      = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    e_pr = 1'b1; e_dr = 1'b0; e_rdy = 1'b0; e_flt = 1'b0; e_rc = 4'd0; e_llc = 8'd0;
    push_exp(0, "reset_state");
    #1 rst_n = 1'b0;

    // Normal bring-up: pll_rst high for 4 edges, lock 10 cycles after its fall.
    wait_until(3);
    rst_n = 1'b1;
    e_pr = 1'b0; push_exp(7, "bringup_prst_fall");
    wait_until(17);
    pll_locked = 1'b1;
    e_dr = 1'b1; e_rdy = 1'b1; push_exp(28, "bringup_run");
    wait_until(28);

    // Restart from RUN, then a 3-cycle lock drop inside STABLE.
    k = cyc;
    restart = 1'b1;
    e_pr = 1'b1; e_dr = 1'b0; e_rdy = 1'b0; push_exp(k + 1, "restart_from_run");
    e_pr = 1'b0; push_exp(k + 5, "glitch_prst_fall");
    e_dr = 1'b1; e_rdy = 1'b1; push_exp(k + 22, "glitch_fresh_run");
    wait_until(k + 1);  restart = 1'b0;
    wait_until(k + 8);  pll_locked = 1'b0;
    wait_until(k + 11); pll_locked = 1'b1;
    wait_until(k + 22);

    // Lock lost in RUN and never regained: two timeouts, then FAULT.
    d = cyc;
    pll_locked = 1'b0;
    e_pr = 1'b1; e_dr = 1'b0; e_rdy = 1'b0; e_llc = 8'd1; push_exp(d + 3, "run_lock_loss");
    e_pr = 1'b0; push_exp(d + 7, "loss_prst_fall");
    e_pr = 1'b1; e_rc = 4'd1; push_exp(d + 27, "timeout_1");
    e_pr = 1'b0; push_exp(d + 31, "retry_prst_fall");
    e_pr = 1'b1; e_rc = 4'd2; e_flt = 1'b1; push_exp(d + 51, "fault_entry");
    wait_until(d + 60);

    // Restart out of FAULT; lock arrives exactly on the timeout cycle.
    r = cyc;
    restart = 1'b1;
    e_flt = 1'b0; e_rc = 4'd0; push_exp(r + 1, "restart_from_fault");
    e_pr = 1'b0; push_exp(r + 5, "fault_restart_prst_fall");
    e_dr = 1'b1; e_rdy = 1'b1; push_exp(r + 33, "lock_beats_timeout");
    wait_until(r + 1);  restart = 1'b0;
    wait_until(r + 22); pll_locked = 1'b1;
    wait_until(r + 33);

    // Restart on the cycle that would enter RUN.
    k = cyc;
    restart = 1'b1;
    e_pr = 1'b1; e_dr = 1'b0; e_rdy = 1'b0; push_exp(k + 1, "restart_from_run_2");
    e_pr = 1'b0; push_exp(k + 5, "entry_test_prst_fall");
    e_pr = 1'b1; push_exp(k + 14, "restart_beats_run_entry");
    e_pr = 1'b0; push_exp(k + 18, "entry_test_prst_fall_2");
    e_dr = 1'b1; e_rdy = 1'b1; push_exp(k + 27, "entry_test_run");
    wait_until(k + 1);  restart = 1'b0;
    wait_until(k + 13); restart = 1'b1;
    wait_until(k + 14); restart = 1'b0;
    wait_until(k + 27);

    // 300 loss/relock cycles; lock_loss_cnt saturates at 255.
    for (int i = 0; i < 300; i++) begin
      k = cyc;
      pll_locked = 1'b0;
      e_pr = 1'b1; e_dr = 1'b0; e_rdy = 1'b0;
      e_llc = (e_llc == 8'd255) ? 8'd255 : e_llc + 8'd1;
      push_exp(k + 3, "loop_loss");
      e_pr = 1'b0; push_exp(k + 7, "loop_prst_fall");
      e_dr = 1'b1; e_rdy = 1'b1; push_exp(k + 16, "loop_relock_run");
      wait_until(k + 2); pll_locked = 1'b1;
      wait_until(k + 16);
    end

    // Asynchronous reset in the middle of STABLE.
    k = cyc;
    restart = 1'b1;
    e_pr = 1'b1; e_dr = 1'b0; e_rdy = 1'b0; push_exp(k + 1, "restart_before_async");
    e_pr = 1'b0; push_exp(k + 5, "async_test_prst_fall");
    wait_until(k + 1); restart = 1'b0;
    wait_until(k + 9);
    #2 rst_n = 1'b0;
    e_pr = 1'b1; e_llc = 8'd0; push_exp(k + 10, "async_reset_event");
    #1;
    checks++;
    if (outs !== {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
      errors++;
      $display("FAIL async_reset_immediate: out=%h, required out=%h", outs, 16'h8000);
    end
    wait_until(k + 14);
    rst_n = 1'b1;
    c1 = k + 14;
    e_pr = 1'b0; push_exp(c1 + 4, "rerelease_prst_fall");
    e_dr = 1'b1; e_rdy = 1'b1; push_exp(c1 + 13, "rerelease_run");
    wait_until(c1 + 20);

    checks++;
    if (q_cyc.size() != 0) begin
      errors++;
      $display("FAIL queue_drained: pending=%0d (next %s at cycle %0d), required pending=0",
               q_cyc.size(), q_nm[0], q_cyc[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
